// File: rtl/thor2024_commit_head.sv
// ---------------------------------------------------------------------------
// thor2024_commit_head
//
// Commit head of the Thor2024 instruction queue. Looks at the two oldest
// entries (head0, head1) of an 8-entry circular queue and retires up to two
// completed instructions per cycle, in program order. Invalid slots between
// head0 and tail0 (bubbles) are skipped. An excepting instruction at head0
// parks the head in the EXC state until the exception handler acknowledges
// it, and the entry is then dequeued.
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous, active-high reset
//   stall         freezes retirement, skipping, head movement and counting
//   tail0         next enqueue slot (used to tell a bubble from an empty queue)
//   iq_v          per-entry valid
//   iq_done       per-entry result done
//   iq_rfw        per-entry writes-register flag
//   iq_exc        per-entry exception flag
//   iq_tgt        per-entry target register
//   exc_ack       exception handler accepts the pending exception
//   head0, head1  queue head pointers (head1 = head0 + 1 mod 8)
//   commit0_*     register-write commit from head0 this cycle
//   commit1_*     register-write commit from head1 this cycle
//   iq_clr        per-entry dequeue strobe (queue owner clears at next edge)
//   exc_v, exc_id registered pending-exception flag and entry id
//   retired       registered retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module thor2024_commit_head #(
    parameter int CNT_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [2:0]       tail0,
    input  logic [7:0]       iq_v,
    input  logic [7:0]       iq_done,
    input  logic [7:0]       iq_rfw,
    input  logic [7:0]       iq_exc,
    input  logic [7:0][5:0]  iq_tgt,
    input  logic             exc_ack,
    output logic [2:0]       head0,
    output logic [2:0]       head1,
    output logic             commit0_v,
    output logic             commit1_v,
    output logic [5:0]       commit0_tgt,
    output logic [5:0]       commit1_tgt,
    output logic [4:0]       commit0_id,
    output logic [4:0]       commit1_id,
    output logic [7:0]       iq_clr,
    output logic             exc_v,
    output logic [4:0]       exc_id,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic {
        RUN = 1'b0,
        EXC = 1'b1
    } state_t;

    state_t     state;
    logic       ret0;
    logic       ret1;
    logic       exc0;
    logic       skip;
    logic [1:0] adv;

    // 3-bit arithmetic gives the mod-8 wrap for free.
    assign head1 = head0 + 3'd1;

    assign commit0_tgt = iq_tgt[head0];
    assign commit1_tgt = iq_tgt[head1];
    assign commit0_id  = {2'b00, head0};
    assign commit1_id  = {2'b00, head1};

    // NOTE: every signal driven from always_comb is given a default first,
    // so no path through the case/if leaves it unassigned (no latch).
    always_comb begin
        ret0   = 1'b0;
        ret1   = 1'b0;
        exc0   = 1'b0;
        skip   = 1'b0;
        iq_clr = 8'h00;
        if (state == RUN && !stall) begin
            exc0 = iq_v[head0] & iq_done[head0] & iq_exc[head0];
            ret0 = iq_v[head0] & iq_done[head0] & ~iq_exc[head0];
            // head1 only retires behind head0 to keep program order.
            ret1 = ret0 & iq_v[head1] & iq_done[head1] & ~iq_exc[head1];
            // An invalid head0 with entries still behind it is a bubble;
            // with head0 == tail0 the queue is simply empty.
            skip = ~iq_v[head0] & (head0 != tail0);
            iq_clr[head0] = ret0;
            iq_clr[head1] = ret1;
        end else if (state == EXC) begin
            iq_clr[head0] = exc_ack;
        end
    end

    assign commit0_v = ret0 & iq_rfw[head0];
    assign commit1_v = ret1 & iq_rfw[head1];
    assign adv       = {1'b0, ret0} + {1'b0, ret1};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            head0   <= 3'd0;
            exc_v   <= 1'b0;
            exc_id  <= 5'd0;
            retired <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!stall) begin
                        if (exc0) begin
                            exc_v  <= 1'b1;
                            exc_id <= {2'b00, head0};
                            state  <= EXC;
                        end else if (skip) begin
                            head0 <= head0 + 3'd1;
                        end else begin
                            head0   <= head0 + 3'(adv);
                            retired <= retired + CNT_W'(adv);
                        end
                    end
                end
                EXC: begin
                    // The handler's acknowledge is honoured even under stall.
                    if (exc_ack) begin
                        head0 <= head0 + 3'd1;
                        exc_v <= 1'b0;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_thor2024_commit_head.sv
// ---------------------------------------------------------------------------
// tb_thor2024_commit_head
//
// Directed bench for thor2024_commit_head, built with a 4-bit retired
// counter so the wrap of the counter is reachable. A table of one-cycle
// vectors walks the head around the queue; hand sequences then cover the
// exception state and an asynchronous reset taken while in it.
// ---------------------------------------------------------------------------
module tb_thor2024_commit_head;

    localparam int CNT_W = 4;
    localparam int NV    = 17;

    logic             clk;
    logic             rst;
    logic             stall;
    logic [2:0]       tail0;
    logic [7:0]       iq_v;
    logic [7:0]       iq_done;
    logic [7:0]       iq_rfw;
    logic [7:0]       iq_exc;
    logic [7:0][5:0]  iq_tgt;
    logic             exc_ack;
    logic [2:0]       head0;
    logic [2:0]       head1;
    logic             commit0_v;
    logic             commit1_v;
    logic [5:0]       commit0_tgt;
    logic [5:0]       commit1_tgt;
    logic [4:0]       commit0_id;
    logic [4:0]       commit1_id;
    logic [7:0]       iq_clr;
    logic             exc_v;
    logic [4:0]       exc_id;
    logic [CNT_W-1:0] retired;

    thor2024_commit_head #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .tail0       (tail0),
        .iq_v        (iq_v),
        .iq_done     (iq_done),
        .iq_rfw      (iq_rfw),
        .iq_exc      (iq_exc),
        .iq_tgt      (iq_tgt),
        .exc_ack     (exc_ack),
        .head0       (head0),
        .head1       (head1),
        .commit0_v   (commit0_v),
        .commit1_v   (commit1_v),
        .commit0_tgt (commit0_tgt),
        .commit1_tgt (commit1_tgt),
        .commit0_id  (commit0_id),
        .commit1_id  (commit1_id),
        .iq_clr      (iq_clr),
        .exc_v       (exc_v),
        .exc_id      (exc_id),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             stall;
        logic [2:0]       tail;
        logic [7:0]       v;
        logic [7:0]       d;
        logic [7:0]       rfw;
        logic [7:0]       exc;
        logic             ack;
        logic             c0;
        logic             c1;
        logic [7:0]       clr;
        logic [2:0]       nh;
        logic [CNT_W-1:0] nret;
    } vec_t;

    vec_t vecs [NV];
    int   checks = 0;
    int   errors = 0;
    logic [2:0] exp_head;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic [2:0] t, input logic [7:0] v,
                         input logic [7:0] d, input logic [7:0] r, input logic [7:0] e,
                         input logic a);
        stall   = s;
        tail0   = t;
        iq_v    = v;
        iq_done = d;
        iq_rfw  = r;
        iq_exc  = e;
        exc_ack = a;
    endtask

    // Target of entry i is 5 + 4*i, so entries 0/1 target registers 5/9.
    function automatic logic [5:0] tgt_of(input logic [2:0] idx);
        return 6'(5 + 4 * int'(idx));
    endfunction

    initial begin
        //        stall tail v      d      rfw    exc    ack c0 c1 clr    nh  nret
        vecs[0]  = '{0, 0, 8'h03, 8'h03, 8'h03, 8'h00, 0, 1, 1, 8'h03, 2, 2};   // dual commit from reset
        vecs[1]  = '{0, 0, 8'h0C, 8'h04, 8'h0C, 8'h00, 0, 1, 0, 8'h04, 3, 3};   // head1 not done
        vecs[2]  = '{0, 0, 8'h08, 8'h08, 8'h00, 8'h00, 0, 0, 0, 8'h08, 4, 4};   // retire, no reg write
        vecs[3]  = '{1, 0, 8'h30, 8'h30, 8'h30, 8'h00, 0, 0, 0, 8'h00, 4, 4};   // stall freezes all
        vecs[4]  = '{0, 0, 8'h30, 8'h30, 8'h30, 8'h20, 0, 1, 0, 8'h10, 5, 5};   // exc on head1 only
        vecs[5]  = '{0, 0, 8'h60, 8'h60, 8'h40, 8'h00, 0, 0, 1, 8'h60, 7, 7};   // rfw only on head1
        vecs[6]  = '{0, 0, 8'h81, 8'h81, 8'h01, 8'h00, 0, 0, 1, 8'h81, 1, 9};   // wrap 7->0
        vecs[7]  = '{0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 9};   // empty queue holds
        vecs[8]  = '{0, 3, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 2, 9};   // bubble skip
        vecs[9]  = '{0, 0, 8'h04, 8'h00, 8'h04, 8'h00, 1, 0, 0, 8'h00, 2, 9};   // not done, ack ignored
        vecs[10] = '{0, 0, 8'h0C, 8'h0C, 8'h0C, 8'h00, 0, 1, 1, 8'h0C, 4, 11};
        vecs[11] = '{0, 0, 8'h30, 8'h30, 8'h00, 8'h00, 0, 0, 0, 8'h30, 6, 13};
        vecs[12] = '{0, 0, 8'hC0, 8'hC0, 8'hC0, 8'h00, 0, 1, 1, 8'hC0, 0, 15};  // counter at max
        vecs[13] = '{0, 0, 8'h03, 8'h03, 8'h03, 8'h00, 0, 1, 1, 8'h03, 2, 1};   // counter wraps 15+2 -> 1
        vecs[14] = '{0, 0, 8'h04, 8'h04, 8'h04, 8'h00, 0, 1, 0, 8'h04, 3, 2};
        vecs[15] = '{0, 3, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 3, 2};   // head0==tail0: hold at 3
        vecs[16] = '{0, 5, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 4, 2};   // bubble at 3, tail 5

        for (int i = 0; i < 8; i++) iq_tgt[i] = tgt_of(3'(i));
        drive(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        rst = 1'b1;
        #12;
        check("rst_head0", head0, 3'd0);
        check("rst_head1", head1, 3'd1);
        check("rst_exc_v", exc_v, 1'b0);
        check("rst_exc_id", exc_id, 5'd0);
        check("rst_retired", retired, 0);
        check("rst_clr", iq_clr, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;
        exp_head = 3'd0;

        for (int i = 0; i < NV; i++) begin
            logic [2:0] h1;
            h1 = exp_head + 3'd1;
            drive(vecs[i].stall, vecs[i].tail, vecs[i].v, vecs[i].d, vecs[i].rfw,
                  vecs[i].exc, vecs[i].ack);
            #2;
            check($sformatf("v%0d_head0", i), head0, exp_head);
            check($sformatf("v%0d_head1", i), head1, h1);
            check($sformatf("v%0d_c0", i), commit0_v, vecs[i].c0);
            check($sformatf("v%0d_c1", i), commit1_v, vecs[i].c1);
            check($sformatf("v%0d_clr", i), iq_clr, vecs[i].clr);
            check($sformatf("v%0d_id0", i), commit0_id, {2'b00, exp_head});
            check($sformatf("v%0d_id1", i), commit1_id, {2'b00, h1});
            check($sformatf("v%0d_tgt0", i), commit0_tgt, tgt_of(exp_head));
            check($sformatf("v%0d_tgt1", i), commit1_tgt, tgt_of(h1));
            @(posedge clk); #1;
            check($sformatf("v%0d_next_head", i), head0, vecs[i].nh);
            check($sformatf("v%0d_retired", i), retired, vecs[i].nret);
            check($sformatf("v%0d_exc_v", i), exc_v, 1'b0);
            exp_head = vecs[i].nh;
        end

        // Exception at head0 = 2: enter EXC, hold, then acknowledge.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        drive(0, 0, 8'h03, 8'h03, 8'h00, 8'h00, 0);
        @(posedge clk); #1;
        check("exc_setup_head", head0, 3'd2);
        drive(0, 0, 8'h04, 8'h04, 8'h04, 8'h04, 0);
        #2;
        check("exc_entry_c0", commit0_v, 1'b0);
        check("exc_entry_clr", iq_clr, 8'h00);
        @(posedge clk); #1;
        check("exc_v_set", exc_v, 1'b1);
        check("exc_id", exc_id, 5'd2);
        check("exc_head_hold", head0, 3'd2);
        check("exc_retired", retired, 2);
        for (int k = 0; k < 3; k++) begin
            drive(1'(k), 0, 8'h0C, 8'h0C, 8'h0C, 8'h04, 0);
            #2;
            check($sformatf("exc_hold%0d_c0", k), commit0_v, 1'b0);
            check($sformatf("exc_hold%0d_c1", k), commit1_v, 1'b0);
            check($sformatf("exc_hold%0d_clr", k), iq_clr, 8'h00);
            @(posedge clk); #1;
            check($sformatf("exc_hold%0d_head", k), head0, 3'd2);
            check($sformatf("exc_hold%0d_exc_v", k), exc_v, 1'b1);
        end
        drive(1, 0, 8'h0C, 8'h0C, 8'h0C, 8'h04, 1);
        #2;
        check("ack_clr", iq_clr, 8'h04);
        check("ack_c0", commit0_v, 1'b0);
        @(posedge clk); #1;
        check("ack_head", head0, 3'd3);
        check("ack_exc_v", exc_v, 1'b0);
        check("ack_retired", retired, 2);

        // Exception at head0 = 3, then reset asynchronously while in EXC.
        drive(0, 0, 8'h08, 8'h08, 8'h00, 8'h08, 0);
        @(posedge clk); #1;
        check("exc2_v", exc_v, 1'b1);
        check("exc2_id", exc_id, 5'd3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_exc_v", exc_v, 1'b0);
        check("async_rst_head", head0, 3'd0);
        check("async_rst_exc_id", exc_id, 5'd0);
        check("async_rst_retired", retired, 0);
        drive(0, 0, 8'h03, 8'h03, 8'h01, 8'h00, 0);
        #1;
        rst = 1'b0;
        #1;
        // Back in RUN: the ready pair at 0/1 commits immediately.
        check("post_rst_c0", commit0_v, 1'b1);
        check("post_rst_clr", iq_clr, 8'h03);
        @(posedge clk); #1;
        check("post_rst_head", head0, 3'd2);
        check("post_rst_retired", retired, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
